// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with NOP injection and flush.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered ready_o.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             nop_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occupancy_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] in_beat;
  logic             fire_in, fire_out;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;

  // Ready is registered so ready_i never reaches ready_o combinationally.
  assign ready_o = ready_q & ~rst;
  assign ready_d = (state_d != StFull);
`else
  assign ready_o = ~rst & (~valid_o | ready_i);
`endif

  assign valid_o     = (state_q != StEmpty);
  assign data_o      = main_q;
  assign occupancy_o = state_q;
  assign fire_in     = valid_i & ready_o;
  assign fire_out    = valid_o & ready_i;
  assign in_beat     = nop_i ? NOP_VALUE : data_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = NOP_VALUE;
`endif
    end else begin
      case (state_q)
        StEmpty: begin
          if (fire_in) begin
            state_d = StHalf;
            main_d  = in_beat;
          end
        end
        StHalf: begin
          if (fire_in && fire_out) begin
            main_d = in_beat;
`ifdef PIPE_STAGE_SKID_EN
          end else if (fire_in) begin
            state_d = StFull;
            skid_d  = in_beat;
`endif
          end else if (fire_out) begin
            state_d = StEmpty;
            main_d  = NOP_VALUE;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        StFull: begin
          if (fire_out) begin
            state_d = StHalf;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
`endif
        default: begin
          state_d = StEmpty;
          main_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= NOP_VALUE;
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
      ready_q <= ready_d;
`endif
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that replaces the fixed-field, stall/nop-driven stage latches between CPU pipeline stages. It moves a WIDTH-bit payload with a valid/ready handshake, and supports bubble (NOP) injection and whole-stage flush. An optional 2-entry skid buffer registers the backpressure path. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage's fields concatenated into data_i.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- NOP_VALUE, {WIDTH{1'b0}} | 32'h00000013 for the IF/ID instance: payload substituted on nop_i and driven whenever valid_o=0.

- clk  in  1  rising-edge clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  stage can accept a beat.
- data_i  in  WIDTH  upstream payload.
- nop_i  in  1  accepted beat is stored as NOP_VALUE instead of data_i.
- flush_i  in  1  discard all held beats.
- valid_o  out  1  downstream beat valid.
- ready_i  in  1  downstream accepts.
- data_o  out  WIDTH  downstream payload; NOP_VALUE when valid_o=0.
- occupancy_o  out  2  held beats (0..2; 0..1 without skid).

## Operation
- fire_in = valid_i & ready_o; fire_out = valid_o & ready_i.
- Stored payload on fire_in = nop_i ? NOP_VALUE : data_i. A NOP beat is still a valid beat and occupies a slot.
- Skid mode states: EMPTY(0), HALF(1), FULL(2). Entries are main (drives data_o) and skid.
  - EMPTY: fire_in -> HALF, main<=in.
  - HALF: fire_in&fire_out -> HALF, main<=in. fire_in only -> FULL, skid<=in. fire_out only -> EMPTY, main<=NOP_VALUE.
  - FULL: ready_o=0. fire_out -> HALF, main<=skid, skid<=NOP_VALUE.
- ready_o = (state != FULL) & ~rst, taken from a register, with no combinational path from ready_i.
- valid_o = (state != EMPTY). occupancy_o = state encoding.
- flush_i (priority over everything except rst): next state EMPTY, both entries <= NOP_VALUE. A concurrent fire_in is consumed and discarded. A concurrent fire_out still counts as delivered to downstream.
- nop_i is ignored when valid_i=0.

## Timing
- Reset (rst high at an edge) sets: valid_o=0, data_o=NOP_VALUE, occupancy_o=0. ready_o=0 while rst is high and 1 on the first cycle after release.
- Reset mid-operation drops all held beats with no output glitch beyond the edge. Inputs are ignored while rst is high.
- Latency: beat accepted at edge N appears on data_o/valid_o after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained when ready_i=1.
- Backpressure: with ready_i low, the stage absorbs up to 2 beats (skid mode), then ready_o falls one cycle after the second accept.
- Ordering is strict FIFO. No beat is duplicated or lost except by flush_i or rst.

## Configuration
- PIPE_STAGE_SKID_EN defined: 2-entry skid buffer as above, with registered ready_o.
- PIPE_STAGE_SKID_EN undefined: single entry. Behaviour:
  - ready_o = ~rst & (~valid_o | ready_i), combinational from ready_i.
  - States are EMPTY/HALF only, and occupancy_o ≤ 1.
  - flush_i, nop_i, reset and latency rules are unchanged.

## Test plan
- Streaming: rst 2 cycles, then valid_i=1, ready_i=1, data_i=1,2,3,4 on consecutive cycles -> data_o=1,2,3,4 one cycle later each, valid_o continuous, ready_o stays 1.
- Backpressure (skid): ready_i=0, push A,B,C -> A,B accepted, occupancy_o=2, ready_o=0 from the cycle after B, C held upstream. Raise ready_i -> A,B,C delivered in order with no loss.
- NOP injection: push 0xDEADBEEF with nop_i=1 (IF/ID instance) -> valid_o=1, data_o=0x00000013.
- Flush: with occupancy_o=2, assert flush_i together with valid_i=1 (data 0x55) -> next cycle valid_o=0, occupancy_o=0, data_o=NOP_VALUE, and 0x55 never appears.
- Reset mid-stream: assert rst while FULL -> next cycle valid_o=0, ready_o=0. Release -> ready_o=1 and fresh data passes with 1-cycle latency.
- Non-skid build: ready_i=0 with one beat held -> ready_o=0 in the same cycle. Toggle ready_i=1 -> ready_o=1 combinationally and accept+deliver happen in the same cycle.
